iiitb_ring_phase_monitor: RTL and testbench
===========================================

// Module: iiitb_ring_phase_monitor
// PURPOSE
//  Downstream checker for the 3-bit ring-counter phase bus (100->010->001->100).
//  Checks each valid sample: it must be one-hot and the rotate-right successor of the previous valid sample.
//  Locks after LOCK_N consecutive legal transitions, counts full rotations and flags/counts faults.
//  Feeds status to LA/GPIO observation logic in the user project.
// PARAMETERS
//  LOCK_N  4   consecutive legal transitions required to enter LOCKED (>=1)
//  CNT_W   16  rotation counter width
//  ERR_W   8   error counter width
// PORTS
//  wb_clk_i     in   1      sole clock, rising edge
//  wb_rst_i     in   1      synchronous reset, active-high
//  phase_i      in   3      ring-counter phase sample
//  phase_vld_i  in   1      1 = phase_i valid this cycle; 0 = ignored (stall)
//  clr_i        in   1      clears err_o, err_cnt_o, last_bad_o, rot_cnt_o
//  locked_o     out  1      1 while FSM in LOCKED
//  err_o        out  1      sticky fault flag
//  err_cnt_o    out  ERR_W  fault count, saturating
//  last_bad_o   out  3      phase_i value of most recent fault
//  rot_cnt_o    out  CNT_W  completed rotations while locked, wraps
//  rot_pulse_o  out  1      1-cycle pulse per completed rotation
// BEHAVIOUR
//  - All outputs registered; a sample taken at edge N is reflected in the outputs after edge N.
//  - Reset (wb_rst_i=1 at an edge): state=HUNT, lock_cnt=0, prev_vld=0.
//    All outputs go to 0. Reset overrides every other input, including mid-lock.
//  - succ(p) = {p[0],p[2:1]}. onehot(p) = p is in {100,010,001}.
//  - Legal transition: phase_vld_i=1, prev_vld=1, onehot(prev), phase_i==succ(prev).
//  - Each valid sample loads prev<=phase_i and sets prev_vld<=1.
//  - phase_vld_i=0: no state change, no check, prev held. A repeated value is illegal only when both samples are valid.
//  - FSM:
//    HUNT: legal transition -> lock_cnt++. On reaching LOCK_N -> LOCKED, lock_cnt<=0.
//      Valid sample that is not a legal transition -> lock_cnt<=0. No error is raised in HUNT.
//      The first valid sample after reset or FAULT only seeds prev.
//    LOCKED: valid sample that is not a legal transition -> FAULT.
//      At that edge: err_o<=1, err_cnt_o++ (saturates at 2^ERR_W-1), last_bad_o<=phase_i, locked_o<=0.
//      Legal transition with phase_i==100 -> rot_cnt_o++ (wraps to 0), rot_pulse_o=1 for one cycle.
//    FAULT: one cycle, then unconditionally -> HUNT with lock_cnt=0.
//      prev_vld<=0 on entry, so the next valid sample (even one arriving in the FAULT cycle) only seeds prev.
//  - locked_o=1 exactly while state==LOCKED.
//  - clr_i=1: at that edge err_o, err_cnt_o, last_bad_o and rot_cnt_o go to 0. FSM is unaffected.
//    If a fault is detected in the same cycle, the fault wins: err_o=1, err_cnt_o=1, last_bad_o=phase_i.
//    If a rotation completes in the same cycle: rot_cnt_o=1 and the pulse is still issued.
//  - rot_pulse_o is 0 in every cycle that has no completed rotation.
// TESTING
//  1 Reset, LOCK_N=4, vld=1, feed 100,010,001,100,010 -> locked_o=1 after 5th sample.
//    Continue to the next 100 -> rot_cnt_o=1, rot_pulse_o single-cycle.
//  2 Locked, inject 110 -> err_o=1, err_cnt_o=1, last_bad_o=110, locked_o=0, FAULT one cycle.
//    Resume legal sequence -> relock after seed plus 4 legal transitions.
//  3 Locked, skip phase 100->001 -> fault, last_bad_o=001.
//    Repeat case 010,010 with vld=1 -> fault, last_bad_o=010.
//  4 Locked, vld=0 for 7 cycles with phase_i=000, then resume at the correct successor -> no fault, locked_o stays 1.
//  5 ERR_W=4, force 20 faults -> err_cnt_o stops at 15.
//    clr_i on the same edge as a fault -> err_cnt_o=1, err_o=1.
//  6 Assert wb_rst_i mid-LOCKED with rot_cnt_o=3 -> all outputs 0 next cycle, state HUNT.
//    CNT_W=2: 4 rotations -> rot_cnt_o wraps to 0.

Source files
------------

// File: rtl/iiitb_ring_phase_monitor.sv
// -----------------------------------------------------------------------------
// iiitb_ring_phase_monitor
//
// Downstream checker for a 3-bit ring-counter phase bus that rotates right
// (100 -> 010 -> 001 -> 100). Every valid sample must be one-hot and the
// rotate-right successor of the previous valid sample. The monitor locks after
// LOCK_N consecutive legal transitions. While locked it counts completed
// rotations and flags/counts any fault. Status feeds LA/GPIO observation logic.
//
// Parameters
//   LOCK_N  consecutive legal transitions needed to enter LOCKED (>= 1)
//   CNT_W   rotation counter width
//   ERR_W   error counter width
//
// Ports
//   wb_clk_i     in   1      sole clock, rising edge
//   wb_rst_i     in   1      synchronous reset, active-high
//   phase_i      in   3      ring-counter phase sample
//   phase_vld_i  in   1      1 = phase_i valid this cycle, 0 = stall (ignored)
//   clr_i        in   1      clears err_o, err_cnt_o, last_bad_o, rot_cnt_o
//   locked_o     out  1      1 while the FSM is in LOCKED
//   err_o        out  1      sticky fault flag
//   err_cnt_o    out  ERR_W  fault count, saturating
//   last_bad_o   out  3      phase_i value of the most recent fault
//   rot_cnt_o    out  CNT_W  completed rotations while locked, wraps
//   rot_pulse_o  out  1      one-cycle pulse per completed rotation
//   dbg_state_o  out  2      FSM state (0 HUNT, 1 LOCKED, 2 FAULT) for observation
//
// Input qualification: phase_i is consumed only in cycles where phase_vld_i is
// 1; there is no back-pressure, every valid sample is accepted on its edge.
// -----------------------------------------------------------------------------
module iiitb_ring_phase_monitor #(
   parameter int LOCK_N = 4,
   parameter int CNT_W  = 16,
   parameter int ERR_W  = 8
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic [2:0]       phase_i,
   input  logic             phase_vld_i,
   input  logic             clr_i,
   output logic             locked_o,
   output logic             err_o,
   output logic [ERR_W-1:0] err_cnt_o,
   output logic [2:0]       last_bad_o,
   output logic [CNT_W-1:0] rot_cnt_o,
   output logic             rot_pulse_o,
   output logic [1:0]       dbg_state_o
);

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_LOCKED = 2'd1,
      ST_FAULT  = 2'd2
   } state_t;

   localparam int LC_W = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
   // lock_cnt value at which the next legal transition is the LOCK_N-th one
   localparam logic [LC_W-1:0] LOCK_LAST = LC_W'(LOCK_N - 1);

   state_t          state, state_nxt;
   logic [LC_W-1:0] lock_cnt, lock_cnt_nxt;
   logic [2:0]      prev;
   logic            prev_vld;

   logic [2:0]      succ_prev;
   logic            prev_onehot;
   logic            legal;
   logic            fault_hit;
   logic            rot_hit;

   // Rotate-right successor of the previous valid sample
   assign succ_prev   = {prev[0], prev[2:1]};
   assign prev_onehot = (prev == 3'b100) || (prev == 3'b010) || (prev == 3'b001);
   // Successor of a one-hot value is one-hot, so phase_i needs no separate check
   assign legal       = phase_vld_i && prev_vld && prev_onehot && (phase_i == succ_prev);

   always_comb begin
      state_nxt    = state;
      lock_cnt_nxt = lock_cnt;
      fault_hit    = 1'b0;
      rot_hit      = 1'b0;
      case (state)
         ST_HUNT: begin
            if (phase_vld_i) begin
               if (legal) begin
                  if (lock_cnt == LOCK_LAST) begin
                     state_nxt    = ST_LOCKED;
                     lock_cnt_nxt = '0;
                  end else begin
                     lock_cnt_nxt = lock_cnt + LC_W'(1);
                  end
               end else begin
                  lock_cnt_nxt = '0;
               end
            end
         end
         ST_LOCKED: begin
            if (phase_vld_i) begin
               if (!legal) begin
                  state_nxt = ST_FAULT;
                  fault_hit = 1'b1;
               end else if (phase_i == 3'b100) begin
                  rot_hit = 1'b1;
               end
            end
         end
         ST_FAULT: begin
            state_nxt    = ST_HUNT;
            lock_cnt_nxt = '0;
         end
         default: begin
            state_nxt    = ST_HUNT;
            lock_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state    <= ST_HUNT;
         lock_cnt <= '0;
         prev     <= 3'b000;
         prev_vld <= 1'b0;
         locked_o <= 1'b0;
      end else begin
         state    <= state_nxt;
         lock_cnt <= lock_cnt_nxt;
         locked_o <= (state_nxt == ST_LOCKED);
         if (phase_vld_i) begin
            prev <= phase_i;
         end
         // A fault discards history: the next valid sample only seeds prev,
         // including one that arrives during the FAULT cycle itself.
         if (fault_hit) begin
            prev_vld <= 1'b0;
         end else if (phase_vld_i) begin
            prev_vld <= 1'b1;
         end
      end
   end

   // Status registers: a fault or rotation on the same edge as clr_i wins,
   // leaving the count at 1 rather than 0.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         err_o       <= 1'b0;
         err_cnt_o   <= '0;
         last_bad_o  <= 3'b000;
         rot_cnt_o   <= '0;
         rot_pulse_o <= 1'b0;
      end else begin
         rot_pulse_o <= rot_hit;

         if (fault_hit) begin
            err_o      <= 1'b1;
            last_bad_o <= phase_i;
            if (clr_i) begin
               err_cnt_o <= ERR_W'(1);
            end else if (err_cnt_o != '1) begin
               err_cnt_o <= err_cnt_o + ERR_W'(1);
            end
         end else if (clr_i) begin
            err_o      <= 1'b0;
            err_cnt_o  <= '0;
            last_bad_o <= 3'b000;
         end

         if (rot_hit) begin
            rot_cnt_o <= clr_i ? CNT_W'(1) : rot_cnt_o + CNT_W'(1);
         end else if (clr_i) begin
            rot_cnt_o <= '0;
         end
      end
   end

   assign dbg_state_o = state;

endmodule

// File: tb/tb_iiitb_ring_phase_monitor.sv
// -----------------------------------------------------------------------------
// tb_iiitb_ring_phase_monitor
//
// Three instances share one stimulus stream:
//   dut_a  default parameters (LOCK_N=4, CNT_W=16, ERR_W=8)
//   dut_e  ERR_W=4  (error counter saturation at 15)
//   dut_c  CNT_W=2  (rotation counter wrap)
// Inputs change on the falling edge; outputs are sampled 1 time unit after the
// rising edge that consumed the sample.
// -----------------------------------------------------------------------------
module tb_iiitb_ring_phase_monitor;

   localparam logic [1:0] S_HUNT   = 2'd0;
   localparam logic [1:0] S_LOCKED = 2'd1;
   localparam logic [1:0] S_FAULT  = 2'd2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [2:0] phase = 3'b000;
   logic       vld   = 1'b0;
   logic       clr   = 1'b0;

   int checks = 0;
   int errors = 0;

   // ---------------- DUT outputs ----------------
   logic        a_locked, a_err, a_pulse;
   logic [7:0]  a_err_cnt;
   logic [2:0]  a_bad;
   logic [15:0] a_rot;
   logic [1:0]  a_st;

   logic        e_locked, e_err, e_pulse;
   logic [3:0]  e_err_cnt;
   logic [2:0]  e_bad;
   logic [15:0] e_rot;
   logic [1:0]  e_st;

   logic        c_locked, c_err, c_pulse;
   logic [7:0]  c_err_cnt;
   logic [2:0]  c_bad;
   logic [1:0]  c_rot;
   logic [1:0]  c_st;

   iiitb_ring_phase_monitor #(.LOCK_N(4), .CNT_W(16), .ERR_W(8)) dut_a (
      .wb_clk_i(clk), .wb_rst_i(rst), .phase_i(phase), .phase_vld_i(vld), .clr_i(clr),
      .locked_o(a_locked), .err_o(a_err), .err_cnt_o(a_err_cnt), .last_bad_o(a_bad),
      .rot_cnt_o(a_rot), .rot_pulse_o(a_pulse), .dbg_state_o(a_st)
   );

   iiitb_ring_phase_monitor #(.LOCK_N(4), .CNT_W(16), .ERR_W(4)) dut_e (
      .wb_clk_i(clk), .wb_rst_i(rst), .phase_i(phase), .phase_vld_i(vld), .clr_i(clr),
      .locked_o(e_locked), .err_o(e_err), .err_cnt_o(e_err_cnt), .last_bad_o(e_bad),
      .rot_cnt_o(e_rot), .rot_pulse_o(e_pulse), .dbg_state_o(e_st)
   );

   iiitb_ring_phase_monitor #(.LOCK_N(4), .CNT_W(2), .ERR_W(8)) dut_c (
      .wb_clk_i(clk), .wb_rst_i(rst), .phase_i(phase), .phase_vld_i(vld), .clr_i(clr),
      .locked_o(c_locked), .err_o(c_err), .err_cnt_o(c_err_cnt), .last_bad_o(c_bad),
      .rot_cnt_o(c_rot), .rot_pulse_o(c_pulse), .dbg_state_o(c_st)
   );

   // ---------------- driver tasks ----------------
   task automatic step(input logic [2:0] p, input logic v, input logic c);
      @(negedge clk);
      phase = p;
      vld   = v;
      clr   = c;
      @(posedge clk);
      #1;
   endtask

   // Seed with 100 then four legal transitions; lock must appear only on the last.
   task automatic relock();
      step(3'b100, 1'b1, 1'b0);
      step(3'b010, 1'b1, 1'b0);
      step(3'b001, 1'b1, 1'b0);
      step(3'b100, 1'b1, 1'b0);
      checks++;
      if (a_locked !== 1'b0) begin
         errors++;
         $display("FAIL relock_early: locked=%b expected 0", a_locked);
      end
      step(3'b010, 1'b1, 1'b0);
      checks++;
      if (a_locked !== 1'b1 || a_st !== S_LOCKED) begin
         errors++;
         $display("FAIL relock: locked=%b state=%0d expected 1/%0d", a_locked, a_st, S_LOCKED);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      step(3'b100, 1'b1, 1'b0);
      step(3'b010, 1'b1, 1'b1);
      checks++;
      if ({a_locked, a_err, a_err_cnt, a_bad, a_rot, a_pulse, a_st} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: locked=%b err=%b cnt=%0d bad=%b rot=%0d pulse=%b st=%0d expected all 0",
                  a_locked, a_err, a_err_cnt, a_bad, a_rot, a_pulse, a_st);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_lock_rotate();
      logic [2:0] seq [5];
      seq = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010};
      for (int i = 0; i < 5; i++) begin
         step(seq[i], 1'b1, 1'b0);
         checks++;
         if (a_locked !== (i == 4)) begin
            errors++;
            $display("FAIL lock_seq[%0d]: locked=%b expected %b", i, a_locked, (i == 4));
         end
      end
      step(3'b001, 1'b1, 1'b0);
      checks++;
      if (a_pulse !== 1'b0 || a_rot !== 16'd0) begin
         errors++;
         $display("FAIL pre_rotation: pulse=%b rot=%0d expected 0/0", a_pulse, a_rot);
      end
      step(3'b100, 1'b1, 1'b0);
      checks++;
      if (a_pulse !== 1'b1 || a_rot !== 16'd1) begin
         errors++;
         $display("FAIL first_rotation: pulse=%b rot=%0d expected 1/1", a_pulse, a_rot);
      end
      step(3'b010, 1'b1, 1'b0);
      checks++;
      if (a_pulse !== 1'b0 || a_rot !== 16'd1) begin
         errors++;
         $display("FAIL pulse_width: pulse=%b rot=%0d expected 0/1", a_pulse, a_rot);
      end
   endtask

   task automatic test_fault_relock();
      step(3'b110, 1'b1, 1'b0);
      checks++;
      if (a_err !== 1'b1 || a_err_cnt !== 8'd1 || a_bad !== 3'b110 || a_locked !== 1'b0 || a_st !== S_FAULT) begin
         errors++;
         $display("FAIL fault_110: err=%b cnt=%0d bad=%b locked=%b st=%0d expected 1/1/110/0/%0d",
                  a_err, a_err_cnt, a_bad, a_locked, a_st, S_FAULT);
      end
      step(3'b000, 1'b0, 1'b0);
      checks++;
      if (a_st !== S_HUNT || a_locked !== 1'b0) begin
         errors++;
         $display("FAIL fault_one_cycle: st=%0d locked=%b expected %0d/0", a_st, a_locked, S_HUNT);
      end
      relock();
      checks++;
      if (a_rot !== 16'd1 || a_err_cnt !== 8'd1) begin
         errors++;
         $display("FAIL after_relock: rot=%0d cnt=%0d expected 1/1", a_rot, a_err_cnt);
      end
   endtask

   task automatic test_skip_repeat();
      step(3'b001, 1'b1, 1'b0);
      step(3'b100, 1'b1, 1'b0);
      checks++;
      if (a_rot !== 16'd2 || a_pulse !== 1'b1) begin
         errors++;
         $display("FAIL rotation_2: rot=%0d pulse=%b expected 2/1", a_rot, a_pulse);
      end
      step(3'b001, 1'b1, 1'b0);
      checks++;
      if (a_err_cnt !== 8'd2 || a_bad !== 3'b001 || a_locked !== 1'b0) begin
         errors++;
         $display("FAIL skip_fault: cnt=%0d bad=%b locked=%b expected 2/001/0", a_err_cnt, a_bad, a_locked);
      end
      // Valid sample during the FAULT cycle only seeds; then 4 legal transitions relock
      step(3'b100, 1'b1, 1'b0);
      checks++;
      if (a_st !== S_HUNT) begin
         errors++;
         $display("FAIL fault_cycle_seed: st=%0d expected %0d", a_st, S_HUNT);
      end
      step(3'b010, 1'b1, 1'b0);
      step(3'b001, 1'b1, 1'b0);
      step(3'b100, 1'b1, 1'b0);
      checks++;
      if (a_locked !== 1'b0 || a_rot !== 16'd2 || a_pulse !== 1'b0) begin
         errors++;
         $display("FAIL hunt_no_rotation: locked=%b rot=%0d pulse=%b expected 0/2/0", a_locked, a_rot, a_pulse);
      end
      step(3'b010, 1'b1, 1'b0);
      checks++;
      if (a_locked !== 1'b1) begin
         errors++;
         $display("FAIL seed_in_fault_relock: locked=%b expected 1", a_locked);
      end
      step(3'b010, 1'b1, 1'b0);
      checks++;
      if (a_err_cnt !== 8'd3 || a_bad !== 3'b010 || a_st !== S_FAULT) begin
         errors++;
         $display("FAIL repeat_fault: cnt=%0d bad=%b st=%0d expected 3/010/%0d", a_err_cnt, a_bad, a_st, S_FAULT);
      end
      step(3'b000, 1'b0, 1'b0);
      relock();
   endtask

   task automatic test_stall();
      for (int i = 0; i < 7; i++) begin
         step(3'b000, 1'b0, 1'b0);
         checks++;
         if (a_locked !== 1'b1 || a_err_cnt !== 8'd3) begin
            errors++;
            $display("FAIL stall[%0d]: locked=%b cnt=%0d expected 1/3", i, a_locked, a_err_cnt);
         end
      end
      step(3'b001, 1'b1, 1'b0);
      checks++;
      if (a_locked !== 1'b1 || a_err_cnt !== 8'd3) begin
         errors++;
         $display("FAIL stall_resume: locked=%b cnt=%0d expected 1/3", a_locked, a_err_cnt);
      end
      step(3'b100, 1'b1, 1'b0);
      checks++;
      if (a_rot !== 16'd3 || c_rot !== 2'd3 || a_pulse !== 1'b1) begin
         errors++;
         $display("FAIL rotation_3: rot=%0d rot_c=%0d pulse=%b expected 3/3/1", a_rot, c_rot, a_pulse);
      end
   endtask

   task automatic test_reset_mid_lock();
      @(negedge clk);
      rst = 1'b1;
      step(3'b010, 1'b1, 1'b0);
      checks++;
      if ({a_locked, a_err, a_err_cnt, a_bad, a_rot, a_pulse, a_st} !== '0) begin
         errors++;
         $display("FAIL reset_mid_lock: locked=%b err=%b cnt=%0d bad=%b rot=%0d pulse=%b st=%0d expected all 0",
                  a_locked, a_err, a_err_cnt, a_bad, a_rot, a_pulse, a_st);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_saturation_clear();
      for (int i = 0; i < 20; i++) begin
         relock();
         step(3'b010, 1'b1, 1'b0);
         step(3'b000, 1'b0, 1'b0);
      end
      checks++;
      if (e_err_cnt !== 4'd15 || a_err_cnt !== 8'd20 || e_err !== 1'b1) begin
         errors++;
         $display("FAIL saturation: cnt_e=%0d cnt_a=%0d err_e=%b expected 15/20/1", e_err_cnt, a_err_cnt, e_err);
      end
      relock();
      step(3'b010, 1'b1, 1'b1);
      checks++;
      if (a_err_cnt !== 8'd1 || e_err_cnt !== 4'd1 || a_err !== 1'b1 || a_bad !== 3'b010) begin
         errors++;
         $display("FAIL clr_with_fault: cnt_a=%0d cnt_e=%0d err=%b bad=%b expected 1/1/1/010",
                  a_err_cnt, e_err_cnt, a_err, a_bad);
      end
      step(3'b000, 1'b0, 1'b0);
      relock();
      step(3'b001, 1'b1, 1'b1);
      checks++;
      if (a_err !== 1'b0 || a_err_cnt !== 8'd0 || a_bad !== 3'b000 || a_locked !== 1'b1) begin
         errors++;
         $display("FAIL clr_alone: err=%b cnt=%0d bad=%b locked=%b expected 0/0/000/1", a_err, a_err_cnt, a_bad, a_locked);
      end
   endtask

   task automatic test_rot_clear_wrap();
      step(3'b100, 1'b1, 1'b1);
      checks++;
      if (a_rot !== 16'd1 || c_rot !== 2'd1 || a_pulse !== 1'b1) begin
         errors++;
         $display("FAIL clr_with_rotation: rot=%0d rot_c=%0d pulse=%b expected 1/1/1", a_rot, c_rot, a_pulse);
      end
      for (int r = 0; r < 3; r++) begin
         step(3'b010, 1'b1, 1'b0);
         step(3'b001, 1'b1, 1'b0);
         step(3'b100, 1'b1, 1'b0);
      end
      checks++;
      if (a_rot !== 16'd4 || c_rot !== 2'd0 || c_pulse !== 1'b1) begin
         errors++;
         $display("FAIL rot_wrap: rot=%0d rot_c=%0d pulse_c=%b expected 4/0/1", a_rot, c_rot, c_pulse);
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_lock_rotate();
      test_fault_relock();
      test_skip_repeat();
      test_stall();
      test_reset_mid_lock();
      test_saturation_clear();
      test_rot_clear_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
